// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core memory subsystem.
// Response ownership encoding and arbiter defaults.
package riscv_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D
    } resp_owner_e;

endpackage

// File: rtl/riscv_mem_arb.sv
// Fetch/data arbiter onto a single-ported memory with one-cycle
// read latency, starvation guard and conflict counter.
module riscv_mem_arb
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 14,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sft_rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           conflict_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0]         r_starve;
    resp_owner_e           r_resp;
    resp_owner_e           w_resp_nxt;
    logic [DATA_WIDTH-1:0] r_if_hold;
    logic [DATA_WIDTH-1:0] r_d_hold;
    logic [31:0]           r_conflict;
    logic                  w_block;
    logic                  w_if_win;

    assign w_block  = !rst_n || sft_rst;
    assign w_if_win = if_req && (!d_req || (r_starve == LIM));

    always_comb begin
        if_gnt    = if_req && !w_block && w_if_win;
        d_gnt     = d_req && !w_block && !w_if_win;
        mem_cs    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (sft_rst) begin
            r_starve <= '0;
        end else if (if_req && !if_gnt) begin
            r_starve <= (r_starve == LIM) ? LIM : r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end

    always_comb begin
        w_resp_nxt = RESP_NONE;
        unique case (1'b1)
            sft_rst:        w_resp_nxt = RESP_NONE;
            if_gnt:         w_resp_nxt = RESP_IF;
            (d_gnt && !d_we): w_resp_nxt = RESP_D;
            default:        w_resp_nxt = RESP_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp <= RESP_NONE;
        end else begin
            r_resp <= w_resp_nxt;
        end
    end

    // A pending response is dropped while soft reset is asserted.
    assign if_rvalid = (r_resp == RESP_IF) && !sft_rst;
    assign d_rvalid  = (r_resp == RESP_D) && !sft_rst;
    assign if_rdata  = if_rvalid ? mem_rdata : r_if_hold;
    assign d_rdata   = d_rvalid ? mem_rdata : r_d_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else if (sft_rst) begin
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            if (if_rvalid) r_if_hold <= mem_rdata;
            if (d_rvalid)  r_d_hold  <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= '0;
        end else if (sft_rst) begin
            r_conflict <= '0;
        end else if (if_req && d_req && !(&r_conflict)) begin
            r_conflict <= r_conflict + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Randomized scoreboard bench for riscv_mem_arb against a
// behavioural arbitration and memory model.
module tb_riscv_mem_arb;
    import riscv_pkg::*;

    localparam int DW  = 64;
    localparam int AW  = 14;
    localparam int LIM = STARVE_LIMIT_DEF;

    typedef struct {
        int          kind;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          sft_rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [31:0]   conflict_cnt;

    riscv_mem_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sft_rst      (sft_rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] ref_mem [64];

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    int    checks = 0;
    int    passed = 0;
    exp_t  q[$];
    bit    mon_en = 0;
    int    m_starve = 0;
    logic [31:0] m_cnt = '0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input logic sr);
        logic          eif;
        logic          ed;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        exp_t          e;
        @(negedge clk);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = wd;
        sft_rst = sr;
        #1;
        // data has priority unless fetch has waited LIM cycles
        eif = !sr && ir && (!dr || m_starve == LIM);
        ed  = !sr && dr && !eif;
        ea  = eif ? ia : (ed ? da : '0);
        ewd = ed ? wd : '0;
        check("grant", {if_gnt, d_gnt}, {eif, ed});
        check("membus", {mem_cs, mem_we, mem_addr, mem_wdata},
              {eif | ed, ed & dw, ea, ewd});
        check("conflict_cnt", conflict_cnt, m_cnt);
        e.kind = eif ? 1 : ((ed && !dw) ? 2 : 0);
        e.data = ref_mem[ea[5:0]];
        q.push_back(e);
        if (ed && dw) ref_mem[da[5:0]] = wd;
        if (sr) begin
            m_starve = 0;
            m_cnt    = '0;
        end else begin
            if (ir && !eif) m_starve = (m_starve == LIM) ? LIM : m_starve + 1;
            else            m_starve = 0;
            if (ir && dr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        exp_t          e;
        logic [DW-1:0] h_if;
        logic [DW-1:0] h_d;
        logic          ev_if;
        logic          ev_d;
        h_if = '0;
        h_d  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_empty: got 0 entries want 1");
                end else begin
                    e     = q.pop_front();
                    ev_if = (e.kind == 1) && !sft_rst;
                    ev_d  = (e.kind == 2) && !sft_rst;
                    check("rvalid", {if_rvalid, d_rvalid}, {ev_if, ev_d});
                    if (ev_if) h_if = e.data;
                    if (ev_d)  h_d  = e.data;
                    check("if_rdata", if_rdata, h_if);
                    check("d_rdata", d_rdata, h_d);
                    if (sft_rst) begin
                        h_if = '0;
                        h_d  = '0;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e0;
        logic [DW-1:0] v;
        for (int i = 0; i < 64; i++) begin
            v = {$urandom, $urandom};
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[16]     = 64'hA5;
        ref_mem[16] = 64'hA5;
        mem_rdata = '0;
        rst_n   = 1'b0;
        sft_rst = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(negedge clk);
        if_req = 1'b1;
        d_req  = 1'b1;
        #1;
        check("rst_grant", {if_gnt, d_gnt}, 2'b00);
        check("rst_outs", {if_rvalid, d_rvalid, mem_cs, mem_we, mem_addr},
              '0);
        check("rst_data", {if_rdata, d_rdata, conflict_cnt}, '0);
        @(posedge clk);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e0.kind = 0;
        e0.data = '0;
        q.push_back(e0);
        #3 mon_en = 1;

        drive(1'b1, 14'h10, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        idle();
        drive(1'b1, 14'h5, 1'b1, 1'b0, 14'h7, '0, 1'b0);
        idle();
        repeat (6) drive(1'b1, 14'h1, 1'b1, 1'b0, 14'h2, '0, 1'b0);
        idle();
        drive(1'b0, '0, 1'b1, 1'b1, 14'h3, 64'h55, 1'b0);
        idle();
        drive(1'b1, 14'h3, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 14'h10, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle();
        idle();

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom % 2), AW'($urandom % 32),
                  1'($urandom % 2), 1'($urandom % 3 == 0),
                  AW'($urandom % 32), {$urandom, $urandom},
                  1'($urandom % 25 == 0));
        end

        idle();
        force dut.r_conflict = 32'hFFFF_FFFF;
        #1;
        release dut.r_conflict;
        m_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 14'h1, 1'b1, 1'b0, 14'h2, '0, 1'b0);
        idle();
        idle();
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arb.md
RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 Parameter DATA_WIDTH, 64: data bus width.
REQ-002 Parameter ADDR_WIDTH, 14: shared memory word-address width.
REQ-003 Parameter STARVE_LIMIT, 4: consecutive denied fetch-request cycles before fetch is forced to win.
REQ-004 Reset rst_n is asynchronous and active-low; the clock is clk.
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sft_rst  input  1  synchronous reset, active-high.
REQ-008 if_req  input  1  fetch read request.
REQ-009 if_addr  input  ADDR_WIDTH  fetch address.
REQ-010 if_gnt  output  1  fetch granted this cycle.
REQ-011 if_rvalid  output  1  fetch read data valid.
REQ-012 if_rdata  output  DATA_WIDTH  fetch read data.
REQ-013 d_req  input  1  data request; d_we  input  1  write when 1.
REQ-014 d_addr  input  ADDR_WIDTH  data address; d_wdata  input  DATA_WIDTH  write data.
REQ-015 d_gnt  output  1  data request granted this cycle.
REQ-016 d_rvalid  output  1  data read valid; d_rdata  output  DATA_WIDTH  data read data.
REQ-017 mem_cs, mem_we  output  1 each  memory select and write enable; mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH.
REQ-018 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after a read select.
REQ-019 conflict_cnt  output  32  saturating count of cycles with if_req and d_req both high.

Function
REQ-020 At most one of if_gnt or d_gnt SHALL be high in any cycle; the grant is combinational, in the same cycle as the request.
- Normal priority: data wins.
- Fetch wins when starve_cnt == STARVE_LIMIT.
- A lone requester is always granted.
REQ-021 starve_cnt SHALL increment when if_req && !if_gnt, saturate at STARVE_LIMIT, and clear when if_gnt or !if_req.
REQ-022 mem_cs = if_gnt | d_gnt and mem_we = d_gnt & d_we. mem_addr and mem_wdata SHALL come from the winner; when idle they are 0.
REQ-023 A response FSM (RESP_NONE, RESP_IF, RESP_D) SHALL register the owner of each granted read: RESP_IF after an if_gnt, RESP_D after a read d_gnt, RESP_NONE otherwise. Writes produce no response.
REQ-024 x_rvalid SHALL be high exactly one cycle after a read grant to x, for one cycle per grant. Back-to-back grants SHALL give back-to-back rvalid.
REQ-025 x_rdata SHALL equal mem_rdata while x_rvalid is high, and otherwise hold x's last captured response, per requester.
REQ-026 conflict_cnt SHALL increment on each conflict cycle and saturate at 0xFFFF_FFFF.

Reset
REQ-027 rst_n low, or sft_rst high at a clk edge, SHALL clear the following: starve_cnt, response FSM (to RESP_NONE), both rdata hold registers, and conflict_cnt.
REQ-028 After reset, all outputs SHALL be 0, and an in-flight read response SHALL be dropped (no rvalid).
REQ-029 Grants SHALL be suppressed while rst_n is low or sft_rst is high.

Structure
REQ-030 The resp_owner_e enum and the STARVE_LIMIT default SHALL live in the shared riscv_pkg.
REQ-031 No sub-module is required; the arbiter, FSM and counters are implemented inline in riscv_mem_arb.

Verification
REQ-032 Scenario: if_req only, if_addr=0x10, mem_rdata=0xA5 next cycle -> if_gnt=1 and mem_addr=0x10; next cycle if_rvalid=1 and if_rdata=0xA5; held afterwards.
REQ-033 Scenario: if_req and d_req (read) simultaneous for one cycle -> d_gnt=1 and if_gnt=0; conflict_cnt=1; next cycle d_rvalid=1 and if_rvalid=0.
REQ-034 Scenario: both requests held high continuously with STARVE_LIMIT=4 -> d_gnt for cycles 0-3, if_gnt on cycle 4, d_gnt on cycle 5.
REQ-035 Scenario: d_req with d_we=1, d_addr=0x3, d_wdata=0x55 -> mem_we=1, mem_addr=0x3 and mem_wdata=0x55; no d_rvalid the following cycle.
REQ-036 Scenario: fetch granted, then sft_rst=1 on the next edge -> if_rvalid stays 0, if_rdata=0 and conflict_cnt=0.
REQ-037 Scenario: conflict_cnt forced to 0xFFFF_FFFF, then a conflict cycle -> conflict_cnt remains 0xFFFF_FFFF.
